// File: rtl/or1200_iter_div.sv
// Iterative 32-cycle restoring divider for l.div / l.divu, with pipeline stall.
// Optional remainder output enabled by `define OR1200_ITER_DIV_REM_EN.
module or1200_iter_div #(
   parameter int OPW = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ex_freeze,
   input  logic           start,
   input  logic           is_signed,
   input  logic [OPW-1:0] operand_a,
   input  logic [OPW-1:0] operand_b,
   output logic           stall,
   output logic           done,
   output logic [OPW-1:0] quotient,
`ifdef OR1200_ITER_DIV_REM_EN
   output logic [OPW-1:0] remainder,
`endif
   output logic           dbz,
   output logic           ovf
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [OPW-1:0] MINV = {1'b1, {(OPW-1){1'b0}}};

   state_t         state_q, state_d;
   logic [5:0]     cnt_q, cnt_d;
   logic [OPW-1:0] dvd_q, dvd_d;
   logic [OPW-1:0] dvs_q, dvs_d;
   logic [OPW-1:0] par_q, par_d;
   logic           qneg_q, qneg_d;
   logic           ovfp_q, ovfp_d;
   logic [OPW-1:0] quot_q, quot_d;
   logic           dbz_q, dbz_d;
   logic           ovf_q, ovf_d;
`ifdef OR1200_ITER_DIV_REM_EN
   logic           rneg_q, rneg_d;
   logic [OPW-1:0] remo_q, remo_d;
`endif

   logic [OPW-1:0] a_abs, b_abs;
   logic [OPW:0]   rem_sh;
   logic [OPW-1:0] sub;
   logic           ge;
   logic [OPW-1:0] par_nx, dvd_nx;

   assign a_abs = (is_signed && operand_a[OPW-1]) ? -operand_a : operand_a;
   assign b_abs = (is_signed && operand_b[OPW-1]) ? -operand_b : operand_b;

   // Partial remainder can exceed OPW bits after the shift, hence the extra bit.
   assign rem_sh = {par_q, dvd_q[OPW-1]};
   assign ge     = rem_sh >= {1'b0, dvs_q};
   assign sub    = rem_sh[OPW-1:0] - dvs_q;
   assign par_nx = ge ? sub : rem_sh[OPW-1:0];
   assign dvd_nx = {dvd_q[OPW-2:0], ge};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      par_d   = par_q;
      qneg_d  = qneg_q;
      ovfp_d  = ovfp_q;
      quot_d  = quot_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
`ifdef OR1200_ITER_DIV_REM_EN
      rneg_d  = rneg_q;
      remo_d  = remo_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               dvd_d  = a_abs;
               dvs_d  = b_abs;
               par_d  = '0;
               qneg_d = is_signed & (operand_a[OPW-1] ^ operand_b[OPW-1]);
               ovfp_d = is_signed & (operand_a == MINV) & (&operand_b);
`ifdef OR1200_ITER_DIV_REM_EN
               rneg_d = is_signed & operand_a[OPW-1];
`endif
               if (operand_b == '0) begin
                  state_d = DONE;
                  quot_d  = '0;
                  dbz_d   = 1'b1;
                  ovf_d   = 1'b0;
`ifdef OR1200_ITER_DIV_REM_EN
                  remo_d  = operand_a;
`endif
               end else begin
                  state_d = RUN;
                  cnt_d   = 6'd32;
               end
            end
         end
         RUN: begin
            cnt_d = cnt_q - 6'd1;
            dvd_d = dvd_nx;
            par_d = par_nx;
            if (cnt_q == 6'd1) begin
               state_d = DONE;
               quot_d  = qneg_q ? -dvd_nx : dvd_nx;
               dbz_d   = 1'b0;
               ovf_d   = ovfp_q;
`ifdef OR1200_ITER_DIV_REM_EN
               remo_d  = rneg_q ? -par_nx : par_nx;
`endif
            end
         end
         DONE: begin
            if (!ex_freeze) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         par_q   <= '0;
         qneg_q  <= 1'b0;
         ovfp_q  <= 1'b0;
         quot_q  <= '0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef OR1200_ITER_DIV_REM_EN
         rneg_q  <= 1'b0;
         remo_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         par_q   <= par_d;
         qneg_q  <= qneg_d;
         ovfp_q  <= ovfp_d;
         quot_q  <= quot_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
`ifdef OR1200_ITER_DIV_REM_EN
         rneg_q  <= rneg_d;
         remo_q  <= remo_d;
`endif
      end
   end

   assign stall    = ((state_q == IDLE) && start) || (state_q == RUN);
   assign done     = (state_q == DONE);
   assign quotient = quot_q;
   assign dbz      = dbz_q;
   assign ovf      = ovf_q;
`ifdef OR1200_ITER_DIV_REM_EN
   assign remainder = remo_q;
`endif

endmodule

// File: tb/tb_or1200_iter_div.sv
// Bench for or1200_iter_div: directed cases plus random divides vs. an
// arithmetic reference model.
module tb_or1200_iter_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_freeze;
   logic        start;
   logic        is_signed;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        stall;
   logic        done;
   logic [31:0] quotient;
   logic        dbz;
   logic        ovf;
`ifdef OR1200_ITER_DIV_REM_EN
   logic [31:0] remainder;
`endif

   int total = 0;
   int bad   = 0;

   or1200_iter_div #(.OPW(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .ex_freeze (ex_freeze),
      .start     (start),
      .is_signed (is_signed),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .stall     (stall),
      .done      (done),
      .quotient  (quotient),
`ifdef OR1200_ITER_DIV_REM_EN
      .remainder (remainder),
`endif
      .dbz       (dbz),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 input bit s, output logic [31:0] q,
                                 output logic [31:0] r, output logic dz,
                                 output logic ov);
      longint la, lb, lq, lr;
      if (b == 32'd0) begin
         q = 32'd0; r = a; dz = 1'b1; ov = 1'b0;
      end else begin
         la = s ? longint'($signed(a)) : longint'({32'd0, a});
         lb = s ? longint'($signed(b)) : longint'({32'd0, b});
         lq = la / lb;
         lr = la % lb;
         q  = lq[31:0];
         r  = lr[31:0];
         dz = 1'b0;
         ov = s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      end
   endfunction

   // One divide; frz holds ex_freeze high for 5 cycles after done.
   task automatic run_div(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input bit s, input bit frz);
      logic [31:0] eq, er;
      logic        edz, eov;
      int          cyc;
      model(a, b, s, eq, er, edz, eov);
      @(negedge clk);
      operand_a = a; operand_b = b; is_signed = s;
      ex_freeze = frz; start = 1'b1;
      #1 chk({tag, ":stall_acc"}, 32'(stall), 32'd1);
      @(posedge clk);
      cyc = 0;
      while (1) begin
         @(negedge clk);
         start = 1'b0;
         operand_a = $urandom; operand_b = $urandom; is_signed = $urandom;
         cyc++;
         if (done || cyc > 40) break;
         chk({tag, ":stall_run"}, 32'(stall), 32'd1);
      end
      chk({tag, ":latency"}, cyc, (b == 32'd0) ? 32'd1 : 32'd33);
      chk({tag, ":done"}, 32'(done), 32'd1);
      chk({tag, ":stall_done"}, 32'(stall), 32'd0);
      chk({tag, ":quot"}, quotient, eq);
      chk({tag, ":dbz"}, 32'(dbz), 32'(edz));
      chk({tag, ":ovf"}, 32'(ovf), 32'(eov));
`ifdef OR1200_ITER_DIV_REM_EN
      chk({tag, ":rem"}, remainder, er);
`endif
      if (frz) begin
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk({tag, ":hold_done"}, 32'(done), 32'd1);
            chk({tag, ":hold_quot"}, quotient, eq);
            chk({tag, ":hold_stall"}, 32'(stall), 32'd0);
            start = (i % 2 == 0);
            operand_a = 32'd50; operand_b = 32'd5;
         end
         @(negedge clk);
         start = 1'b0;
         ex_freeze = 1'b0;
      end
      @(negedge clk);
      chk({tag, ":idle_done"}, 32'(done), 32'd0);
      chk({tag, ":idle_stall"}, 32'(stall), 32'd0);
      chk({tag, ":idle_quot"}, quotient, eq);
      chk({tag, ":idle_dbz"}, 32'(dbz), 32'(edz));
   endtask

   initial begin
      logic [31:0] ra, rb;
      bit          rs;
      rst = 1'b1; ex_freeze = 1'b0; start = 1'b0; is_signed = 1'b0;
      operand_a = 32'd0; operand_b = 32'd0;
      #2;
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_quot", quotient, 32'd0);
      chk("rst_dbz", 32'(dbz), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_div("udiv", 32'd100, 32'd7, 1'b0, 1'b0);
      run_div("sdiv", 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0);
      run_div("dbz", 32'h0000_1234, 32'd0, 1'b0, 1'b0);
      run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_div("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_div("ubig", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b0);
      run_div("hold", 32'd1000, 32'd9, 1'b0, 1'b1);
      run_div("sdbz", 32'hFFFF_FFF0, 32'd0, 1'b1, 1'b0);

      // Reset in the middle of an operation.
      @(negedge clk);
      operand_a = 32'd77777; operand_b = 32'd13; is_signed = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("mid_stall", 32'(stall), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_stall", 32'(stall), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_quot", quotient, 32'd0);
      chk("mid_rst_dbz", 32'(dbz), 32'd0);
      chk("mid_rst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_div("after_rst", 32'd9, 32'd3, 1'b0, 1'b0);

      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = $urandom_range(0, 1);
         case (i % 4)
            1: rb = 32'($urandom_range(1, 300));
            2: rb = (i % 8 == 2) ? 32'd0 : -32'($urandom_range(1, 50));
            default: ;
         endcase
         run_div("rand", ra, rb, rs, (i % 5 == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
